// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the two-digit BCD countdown timer.
package bcd_timer_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // Controller states; the ST_ prefix keeps them clear of the DONE port name.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Switch values above 9 are not valid BCD, so they saturate to 9.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/bcd_tick_gen.sv
// Prescaler: emits a one-cycle TICK every DIV_LEN cycles of running time.
module bcd_tick_gen
  import bcd_timer_pkg::*;
#(
  parameter int DIV_LEN = 50_000_000
) (
  input  logic CLK_50,
  input  logic RST,
  input  logic run,
  input  logic clr,
  output logic TICK
);

  localparam int CNT_W = (DIV_LEN > 1) ? $clog2(DIV_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_LEN - 1);

  logic [CNT_W-1:0] divCnt_q, divCnt_d;
  logic             tick_q, tick_d;

  // Next count: clear wins, otherwise count only while running and hold otherwise.
  always_comb begin
    divCnt_d = divCnt_q;
    tick_d   = 1'b0;
    if (clr) begin
      divCnt_d = '0;
    end else if (run) begin
      if (divCnt_q == LAST) begin
        divCnt_d = '0;
        tick_d   = 1'b1;
      end else begin
        divCnt_d = divCnt_q + 1'b1;
      end
    end
  end

  // Counter and registered tick pulse.
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      divCnt_q <= '0;
      tick_q   <= 1'b0;
    end else begin
      divCnt_q <= divCnt_d;
      tick_q   <= tick_d;
    end
  end

  assign TICK = tick_q;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer: load from switches, count down on prescaled
// ticks, pulse DONE on reaching 00.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int DIV_LEN = 50_000_000
) (
  input  logic       CLK_50,
  input  logic       RST,
  input  logic       EN,
  input  logic       LOAD_N,
  input  logic       START,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       BOUT,
  output logic       BUSY,
  output logic       DONE,
  output logic       TICK
);

  state_t           state_q;
  logic [BCD_W-1:0] tens_q, ones_q;
  logic [BCD_W-1:0] tensDec_d, onesDec_d;
  logic             done_q;
  logic             tick;
  logic             isZero, lastStep;
  logic             loadReq, startAcc, prescRun, prescClr;

  assign isZero   = (tens_q == '0) && (ones_q == '0);
  assign lastStep = (tens_q == '0) && (ones_q == 4'd1);
  assign loadReq  = EN && !LOAD_N;
  assign startAcc = EN && LOAD_N && (state_q == ST_IDLE) && START && !isZero;
  assign prescRun = EN && (state_q == ST_RUN);
  assign prescClr = loadReq || startAcc;

  bcd_tick_gen #(
    .DIV_LEN(DIV_LEN)
  ) u_tick_gen (
    .CLK_50(CLK_50),
    .RST   (RST),
    .run   (prescRun),
    .clr   (prescClr),
    .TICK  (tick)
  );

  // BCD decrement with borrow from ones into tens; tens never wraps below 0.
  always_comb begin
    tensDec_d = tens_q;
    onesDec_d = ones_q;
    if (ones_q != '0) begin
      onesDec_d = ones_q - 1'b1;
    end else begin
      onesDec_d = BCD_MAX;
      tensDec_d = (tens_q != '0) ? tens_q - 1'b1 : '0;
    end
  end

  // Controller FSM, digit registers and the registered DONE pulse.
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      state_q <= ST_IDLE;
      tens_q  <= '0;
      ones_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (EN) begin
        if (!LOAD_N) begin
          tens_q  <= bcd_clamp(DIN[7:4]);
          ones_q  <= bcd_clamp(DIN[3:0]);
          state_q <= ST_IDLE;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (START && !isZero) state_q <= ST_RUN;
            end
            ST_RUN: begin
              if (tick) begin
                tens_q <= tensDec_d;
                ones_q <= onesDec_d;
                if (lastStep) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                end
              end
            end
            ST_PAUSE: begin
              state_q <= ST_RUN;
            end
            ST_DONE: begin
              state_q <= ST_DONE;
            end
            default: begin
              state_q <= ST_IDLE;
            end
          endcase
        end
      end else if (state_q == ST_RUN) begin
        state_q <= ST_PAUSE;
      end
    end
  end

  assign DOUT = {tens_q, ones_q};
  assign BOUT = isZero;
  assign BUSY = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign DONE = done_q;
  assign TICK = tick;

endmodule
